// File: rtl/acorn128_pkg.sv
// Shared ACORN-128 (v3) definitions for the init, encryption and tag stages.
// Holds state/key widths, filter tap positions and the single-step update function.
package acorn128_pkg;

  localparam int ACORN_STATE_W    = 293;
  localparam int ACORN_KEY_W      = 128;
  localparam int ACORN_INIT_STEPS = 1792;
  localparam int ACORN_CNT_W      = 11;

  // LFSR boundary and nonlinear filter tap positions of the 293-bit state
  localparam int TAP_0   = 0;
  localparam int TAP_12  = 12;
  localparam int TAP_23  = 23;
  localparam int TAP_61  = 61;
  localparam int TAP_66  = 66;
  localparam int TAP_107 = 107;
  localparam int TAP_111 = 111;
  localparam int TAP_154 = 154;
  localparam int TAP_160 = 160;
  localparam int TAP_193 = 193;
  localparam int TAP_196 = 196;
  localparam int TAP_230 = 230;
  localparam int TAP_235 = 235;
  localparam int TAP_244 = 244;
  localparam int TAP_289 = 289;

  typedef logic [ACORN_STATE_W-1:0] acorn_state_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } acorn_init_fsm_e;

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic ch(input logic x, input logic y, input logic z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic acorn_ks(input acorn_state_t s);
    return s[TAP_12] ^ s[TAP_154] ^ maj(s[TAP_235], s[TAP_61], s[TAP_193])
         ^ ch(s[TAP_230], s[TAP_111], s[TAP_66]);
  endfunction

  // The six LFSR folds must happen in this order; ks and f see the folded state.
  function automatic acorn_state_t acorn_step(input acorn_state_t state, input logic m,
                                              input logic ca, input logic cb);
    acorn_state_t s;
    logic         ks;
    logic         f;
    s          = state;
    s[TAP_289] = s[TAP_289] ^ s[TAP_235] ^ s[TAP_230];
    s[TAP_230] = s[TAP_230] ^ s[TAP_196] ^ s[TAP_193];
    s[TAP_193] = s[TAP_193] ^ s[TAP_160] ^ s[TAP_154];
    s[TAP_154] = s[TAP_154] ^ s[TAP_111] ^ s[TAP_107];
    s[TAP_107] = s[TAP_107] ^ s[TAP_66]  ^ s[TAP_61];
    s[TAP_61]  = s[TAP_61]  ^ s[TAP_23]  ^ s[TAP_0];
    ks = acorn_ks(s);
    f  = s[TAP_0] ^ ~s[TAP_107] ^ maj(s[TAP_244], s[TAP_23], s[TAP_160])
       ^ (ca & s[TAP_196]) ^ (cb & ks);
    return {f ^ m, s[ACORN_STATE_W-1:1]};
  endfunction

  // Message bit for init step idx: key, then IV, then key with a single flipped bit at 256.
  function automatic logic acorn_init_mbit(input logic [ACORN_KEY_W-1:0] key,
                                           input logic [ACORN_KEY_W-1:0] iv,
                                           input logic [ACORN_CNT_W-1:0] idx);
    if (idx < 11'd128)       return key[idx[6:0]];
    else if (idx < 11'd256)  return iv[idx[6:0]];
    else if (idx == 11'd256) return ~key[0];
    else                     return key[idx[6:0]];
  endfunction

endpackage

// File: rtl/acorn128_step_comb.sv
// Combinational unroll of STEPS_PER_CYCLE consecutive ACORN-128 state-update steps.
// Step j consumes message bit i_m[j]; ca/cb are shared by all steps in the chain.
module acorn128_step_comb
  import acorn128_pkg::*;
#(
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic [ACORN_STATE_W-1:0]   i_state,
  input  logic [STEPS_PER_CYCLE-1:0] i_m,
  input  logic                       i_ca,
  input  logic                       i_cb,
  output logic [ACORN_STATE_W-1:0]   o_state
);

  always_comb begin
    o_state = i_state;
    for (int j = 0; j < STEPS_PER_CYCLE; j++) begin
      o_state = acorn_step(o_state, i_m[j], i_ca, i_cb);
    end
  end

endmodule

// File: rtl/acorn128_init.sv
// ACORN-128 key/IV load and 1792-step initialization, handing the state downstream via valid/ready.
// Optional macro ACORN_INIT_ZEROIZE_EN wipes key/IV and masks/clears the state outside HOLD.
module acorn128_init
  import acorn128_pkg::*;
#(
  parameter int STEPS_PER_CYCLE = 1,
  parameter int INIT_STEPS      = ACORN_INIT_STEPS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ACORN_KEY_W-1:0]   key_in,
  input  logic [ACORN_KEY_W-1:0]   iv_in,
  output logic                     busy,
  output logic                     state_valid,
  input  logic                     state_ready,
  output logic [ACORN_STATE_W-1:0] state_out,
  output logic                     ca_out,
  output logic                     cb_out,
  output logic                     done
);

  localparam logic [ACORN_CNT_W-1:0] CNT_STEP = ACORN_CNT_W'(STEPS_PER_CYCLE);
  localparam logic [ACORN_CNT_W-1:0] CNT_LAST = ACORN_CNT_W'(INIT_STEPS - STEPS_PER_CYCLE);

  acorn_init_fsm_e            r_fsm;
  acorn_init_fsm_e            w_fsm_nxt;
  logic [ACORN_STATE_W-1:0]   r_state;
  logic [ACORN_STATE_W-1:0]   w_state_stepped;
  logic [ACORN_KEY_W-1:0]     r_key;
  logic [ACORN_KEY_W-1:0]     r_iv;
  logic [ACORN_CNT_W-1:0]     r_cnt;
  logic                       r_done;
  logic [STEPS_PER_CYCLE-1:0] w_m;
  logic                       w_load;
  logic                       w_step;
  logic                       w_last;

  always_ff @(posedge clk) begin
    if (rst) r_fsm <= ST_IDLE;
    else     r_fsm <= w_fsm_nxt;
  end

  // HOLD gives start priority so a simultaneous ready completes the transfer and restarts together.
  always_comb begin
    w_fsm_nxt = r_fsm;
    w_load    = 1'b0;
    w_step    = 1'b0;
    w_last    = (r_cnt == CNT_LAST);
    case (r_fsm)
      ST_IDLE: begin
        if (start) begin
          w_load    = 1'b1;
          w_fsm_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_step = 1'b1;
        if (w_last) w_fsm_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (start) begin
          w_load    = 1'b1;
          w_fsm_nxt = ST_RUN;
        end else if (state_ready) begin
          w_fsm_nxt = ST_IDLE;
        end
      end
      default: w_fsm_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_m = '0;
    for (int j = 0; j < STEPS_PER_CYCLE; j++) begin
      w_m[j] = acorn_init_mbit(r_key, r_iv, r_cnt + ACORN_CNT_W'(j));
    end
  end

  acorn128_step_comb #(
    .STEPS_PER_CYCLE(STEPS_PER_CYCLE)
  ) u_step (
    .i_state (r_state),
    .i_m     (w_m),
    .i_ca    (1'b1),
    .i_cb    (1'b1),
    .o_state (w_state_stepped)
  );

`ifdef ACORN_INIT_ZEROIZE_EN
  logic w_xfer;
  assign w_xfer = (r_fsm == ST_HOLD) && state_ready && !start;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= '0;
      r_key   <= '0;
      r_iv    <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_step && w_last;
      if (w_load) begin
        r_key   <= key_in;
        r_iv    <= iv_in;
        r_state <= '0;
        r_cnt   <= '0;
      end else if (w_step) begin
        r_state <= w_state_stepped;
        r_cnt   <= r_cnt + CNT_STEP;
`ifdef ACORN_INIT_ZEROIZE_EN
        if (w_last) begin
          r_key <= '0;
          r_iv  <= '0;
        end
`endif
      end
`ifdef ACORN_INIT_ZEROIZE_EN
      else if (w_xfer) begin
        r_state <= '0;
      end
`endif
    end
  end

  assign busy        = (r_fsm == ST_RUN);
  assign state_valid = (r_fsm == ST_HOLD);
  assign done        = r_done;
  assign ca_out      = state_valid;
  assign cb_out      = 1'b0;

`ifdef ACORN_INIT_ZEROIZE_EN
  assign state_out = state_valid ? r_state : '0;
`else
  assign state_out = r_state;
`endif

endmodule

// File: doc/acorn128_init.md
Name: acorn128_init

Overview:
- Upstream neighbour of the ACORN-128 encryption stage.
- Loads a 128-bit key and 128-bit IV, then runs the 1792-step ACORN-128 initialization on the 293-bit state.
- Presents the resulting state, with ca/cb seed bits, to the encryption stage through a valid/ready handshake.
- Iterative: STEPS_PER_CYCLE state-update steps per clock.

Parameters:
- STEPS_PER_CYCLE, 1, state-update steps unrolled per clock. Legal values: 1, 2, 4, 8, 16. Each divides 1792.
- INIT_STEPS, 1792, total initialization steps. Fixed by the algorithm; exposed for bench shortening only.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request initialization; key_in/iv_in sampled on the accepting edge
- key_in  input  128  key, bit i = K[i]
- iv_in  input  128  IV, bit i = IV[i]
- busy  output  1  high while stepping
- state_valid  output  1  state_out holds a finished initialized state
- state_ready  input  1  downstream (encryption stage) accepts state_out
- state_out  output  293  initialized state S[292:0]
- ca_out  output  1  ca seed for the first encryption step; constant 1 when valid
- cb_out  output  1  cb seed; constant 0 when valid
- done  output  1  one-cycle pulse on the cycle state_valid rises

Behaviour:
- Synchronous reset values: FSM=IDLE; busy=0; state_valid=0; done=0; state_out=0; ca_out=0; cb_out=0; step counter=0; key/IV registers=0.
- rst mid-run aborts immediately; no done is produced.
- FSM states: IDLE, RUN, HOLD.
- IDLE:
  - start=1 latches key/IV, clears state to 0 and counter to 0, then moves to RUN.
  - busy rises the next cycle.
- RUN:
  - Each cycle applies STEPS_PER_CYCLE steps for indices i=cnt..cnt+STEPS_PER_CYCLE-1, then cnt += STEPS_PER_CYCLE.
  - start is ignored.
  - After the step with i=INIT_STEPS-1, moves to HOLD with state_valid=1 and done=1 for one cycle.
- Latency: done asserts INIT_STEPS/STEPS_PER_CYCLE + 1 cycles after the start edge, i.e. 1793 cycles at default.
- HOLD:
  - state_out is stable.
  - state_valid && state_ready transfers the state; next cycle state_valid=0 and the FSM returns to IDLE.
  - start while in HOLD without ready restarts: state_valid drops, key/IV are re-latched, FSM goes to RUN.
  - If start and state_ready are both high, the transfer completes this edge and the restart is accepted on the same edge.
- Message bit per step: m_i = K[i] for i<128; IV[i-128] for 128≤i<256; K[0]^1 for i=256; K[i mod 128] for 257≤i<1792.
- ca=cb=1 for every init step.
- Step function, ACORN v3, applied in order:
  - S289^=S235^S230; S230^=S196^S193; S193^=S160^S154; S154^=S111^S107; S107^=S66^S61; S61^=S23^S0.
  - ks = S12^S154^maj(S235,S61,S193)^ch(S230,S111,S66).
  - f = S0^~S107^maj(S244,S23,S160)^(ca&S196)^(cb&ks).
  - Shift S[j]=S[j+1], then S292 = f^m.
- Counter: 11 bits, no wrap; terminal compare at INIT_STEPS-STEPS_PER_CYCLE.

Optional Feature:
- Macro ACORN_INIT_ZEROIZE_EN.
- Defined:
  - Key/IV registers clear to 0 on the cycle done pulses.
  - state_out is forced to 0 whenever state_valid=0, including during RUN.
  - After a HOLD transfer, the state register is cleared.
- Undefined:
  - Key/IV registers retain their values.
  - state_out shows the live state register at all times.

Decomposition:
- Package acorn128_pkg holds:
  - constants ACORN_STATE_W=293, ACORN_KEY_W=128, ACORN_INIT_STEPS=1792;
  - tap-index localparams;
  - functions maj, ch, acorn_ks, acorn_step(state, m, ca, cb) returning the new state.
- Package users: this block, the encryption stage and the tag stage.
- Sub-module acorn128_step_comb: combinational STEPS_PER_CYCLE-deep unroll of acorn_step with per-step m bits. This block is the FSM, counter and m-bit selector around it.

Test Plan:
- Reset/idle: hold rst 3 cycles, then start=0 for 10 cycles → busy=0, state_valid=0, done=0, state_out=0.
- Known answer:
  - Stimulus: key=0, iv=0, start one cycle, state_ready=0.
  - Required: done exactly 1793 cycles later (1 pulse); state_out equals the C golden-model state; ca_out=1, cb_out=0.
  - Repeat with key=0x000102…0F, iv=0xF0E1…0F.
- Unroll equivalence: STEPS_PER_CYCLE=8, same vectors → identical state_out; done at 225 cycles.
- Handshake: hold state_ready=0 for 50 cycles after done → state_out stable and valid high. Raise ready one cycle → valid drops next cycle, FSM is IDLE.
- Start ignored / restart: pulse start at RUN cycle 100 → completion time unchanged. Pulse start in HOLD with new key → valid drops, new result after 1793 cycles.
- Reset mid-run: assert rst at cycle 900 → all outputs 0 next cycle, no done. A fresh start gives the correct KAT.
